// File: rtl/pm_pkg.sv
// Shared types and constants for the WDPM program memory.
// Holds the ISA opcode/register encodings, the NOP fill word and the loader FSM states.
package pm_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_NOT = 4'b0101,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0111,
    OP_ST  = 4'b1000,
    OP_LD  = 4'b1001,
    OP_NOP = 4'b1010,
    OP_JMP = 4'b1111
  } opcode_t;

  typedef enum logic [3:0] {
    R0  = 4'd0,
    R1  = 4'd1,
    R2  = 4'd2,
    R3  = 4'd3,
    ID  = 4'd4,
    DM0 = 4'd5,
    DM1 = 4'd6,
    DM2 = 4'd7,
    DM3 = 4'd8
  } reg_code_t;

  // NOP opcode in the top nibble, all operand fields zero
  localparam logic [15:0] DEF_NOP_WORD = {OP_NOP, 12'h000};

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2,
    ST_PAD  = 2'd3
  } pm_state_t;

endpackage

// File: rtl/pm_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one registered read port.
// Contents are not reset; the owner is responsible for initialising them.
module pm_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/program_memory.sv
// Loadable instruction memory: self-fills with NOP after reset, reloads over a valid/ready
// stream with NOP padding, and serves fetches with one registered cycle of latency.
module program_memory
  import pm_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DEF_NOP_WORD
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  LD_START,
  input  logic                  LD_VALID,
  input  logic [DATA_WIDTH-1:0] LD_DATA,
  input  logic                  LD_LAST,
  output logic                  LD_READY,
  output logic                  LD_DONE,
  output logic                  LD_OVF,
  output logic                  PROG_READY,
  input  logic                  FETCH_EN,
  input  logic [ADDR_WIDTH-1:0] FETCH_ADDR,
  output logic [DATA_WIDTH-1:0] FETCH_DATA,
  output logic                  FETCH_VALID
);

  localparam int                    DEPTH     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  pm_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
  logic                  ovf, ovf_nxt;
  logic                  done, done_nxt;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  nop_sel;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign LD_READY   = (state == ST_LOAD);
  assign PROG_READY = (state == ST_IDLE);
  assign LD_DONE    = done;
  assign LD_OVF     = ovf;

  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    ovf_nxt     = ovf;
    done_nxt    = 1'b0;
    we          = 1'b0;
    wdata       = NOP_WORD;
    case (state)
      ST_INIT: begin
        we = 1'b1;
        if (wr_addr == LAST_ADDR) state_nxt = ST_IDLE;
        else                      wr_addr_nxt = wr_addr + 1'b1;
      end
      ST_IDLE: begin
        if (LD_START) begin
          state_nxt   = ST_LOAD;
          wr_addr_nxt = '0;
          ovf_nxt     = 1'b0;
        end
      end
      ST_LOAD: begin
        if (LD_VALID) begin
          we    = 1'b1;
          wdata = LD_DATA;
          // The last address always ends the load; the counter is never allowed to wrap
          if (wr_addr == LAST_ADDR) begin
            state_nxt = ST_IDLE;
            ovf_nxt   = !LD_LAST;
            done_nxt  = 1'b1;
          end else begin
            wr_addr_nxt = wr_addr + 1'b1;
            if (LD_LAST) state_nxt = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        we = 1'b1;
        if (wr_addr == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else begin
          wr_addr_nxt = wr_addr + 1'b1;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= ST_INIT;
      wr_addr     <= '0;
      ovf         <= 1'b0;
      done        <= 1'b0;
      nop_sel     <= 1'b1;
      fetch_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_addr <= wr_addr_nxt;
      ovf     <= ovf_nxt;
      done    <= done_nxt;
      if (FETCH_EN) begin
        nop_sel     <= !PROG_READY;
        fetch_valid <= PROG_READY;
      end else begin
        fetch_valid <= 1'b0;
      end
    end
  end

  // nop_sel is registered, so FETCH_DATA is still a registered-only output
  assign FETCH_DATA  = nop_sel ? NOP_WORD : ram_rdata;
  assign FETCH_VALID = fetch_valid;

  pm_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (CLK),
    .we   (we && RST_N),
    .waddr(wr_addr),
    .wdata(wdata),
    .re   (FETCH_EN && PROG_READY),
    .raddr(FETCH_ADDR),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_program_memory.sv
// Bench for program_memory: fetch results are predicted into a queue when the fetch is
// driven and checked when they appear; a local memory model tracks expected contents.
module tb_program_memory;

  localparam logic [15:0] NOP = 16'hA000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        LD_START = 1'b0;
  logic        LD_VALID = 1'b0;
  logic [15:0] LD_DATA = '0;
  logic        LD_LAST = 1'b0;
  logic        LD_READY, LD_DONE, LD_OVF, PROG_READY;
  logic        FETCH_EN = 1'b0;
  logic [4:0]  FETCH_ADDR = '0;
  logic [15:0] FETCH_DATA;
  logic        FETCH_VALID;

  typedef struct {
    logic        vld;
    logic [15:0] dat;
  } fexp_t;

  fexp_t       fq[$];
  logic [15:0] mdl[32];
  logic [15:0] ld_words[32];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 CLK = ~CLK;

  program_memory dut (
    .CLK(CLK), .RST_N(RST_N),
    .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_LAST(LD_LAST),
    .LD_READY(LD_READY), .LD_DONE(LD_DONE), .LD_OVF(LD_OVF), .PROG_READY(PROG_READY),
    .FETCH_EN(FETCH_EN), .FETCH_ADDR(FETCH_ADDR), .FETCH_DATA(FETCH_DATA),
    .FETCH_VALID(FETCH_VALID)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; any fetch requested during the cycle is checked against the queue.
  task automatic tick();
    bit issued;
    fexp_t e;
    issued = FETCH_EN;
    @(posedge CLK);
    #1;
    if (issued) begin
      if (fq.size() == 0) begin
        chk("fetch_queue_empty", 32'd1, 32'd0);
      end else begin
        e = fq.pop_front();
        chk("fetch_valid", {31'd0, FETCH_VALID}, {31'd0, e.vld});
        chk("fetch_data", {16'd0, FETCH_DATA}, {16'd0, e.dat});
      end
    end
  endtask

  task automatic fetch(input int addr, input logic vld, input logic [15:0] dat);
    fexp_t e;
    FETCH_EN   = 1'b1;
    FETCH_ADDR = addr[4:0];
    e.vld = vld;
    e.dat = dat;
    fq.push_back(e);
    tick();
    FETCH_EN = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 32; a++) fetch(a, 1'b1, mdl[a]);
  endtask

  // Load n words from ld_words; optional gaps, a word held in the start cycle, and fetch held.
  task automatic run_load(input int n, input bit use_last, input bit gaps, input bit fetch_hold);
    fexp_t e;
    int    pad;
    int    early;
    if (gaps) begin
      LD_VALID = 1'b1;
      LD_DATA  = 16'hDEAD;
    end
    LD_START = 1'b1;
    tick();
    LD_START = 1'b0;
    LD_VALID = 1'b0;
    chk("load_ready", {31'd0, LD_READY}, 32'd1);
    chk("load_prog_ready", {31'd0, PROG_READY}, 32'd0);
    chk("ovf_cleared", {31'd0, LD_OVF}, 32'd0);
    for (int i = 0; i < 32; i++) mdl[i] = NOP;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        for (int g = 0; g < (i % 4 == 1 ? 1 : 2); g++) begin
          LD_VALID = 1'b0;
          LD_DATA  = 16'hBEEF;
          LD_LAST  = 1'b1;
          if (fetch_hold) begin
            FETCH_EN = 1'b1; e.vld = 1'b0; e.dat = NOP; fq.push_back(e);
          end
          tick();
        end
      end
      LD_VALID = 1'b1;
      LD_DATA  = ld_words[i];
      LD_LAST  = use_last && (i == n - 1);
      mdl[i]   = ld_words[i];
      if (fetch_hold) begin
        FETCH_EN   = 1'b1;
        FETCH_ADDR = i[4:0];
        e.vld = 1'b0; e.dat = NOP; fq.push_back(e);
      end
      tick();
    end
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
    FETCH_EN = 1'b0;
    pad   = (n < 32) ? 32 - n : 0;
    early = 0;
    for (int p = 0; p < pad; p++) begin
      if (LD_DONE) early++;
      tick();
    end
    chk("done_early", early, 32'd0);
    chk("done_pulse", {31'd0, LD_DONE}, 32'd1);
    chk("done_prog_ready", {31'd0, PROG_READY}, 32'd1);
    chk("ovf_flag", {31'd0, LD_OVF}, {31'd0, (n == 32) && !use_last});
    tick();
    chk("done_cleared", {31'd0, LD_DONE}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones;
    for (int i = 0; i < 32; i++) mdl[i] = NOP;

    // Reset state
    repeat (3) tick();
    chk("rst_prog_ready", {31'd0, PROG_READY}, 32'd0);
    chk("rst_ld_ready", {31'd0, LD_READY}, 32'd0);
    chk("rst_ld_done", {31'd0, LD_DONE}, 32'd0);
    chk("rst_ld_ovf", {31'd0, LD_OVF}, 32'd0);
    chk("rst_fetch_valid", {31'd0, FETCH_VALID}, 32'd0);
    chk("rst_fetch_data", {16'd0, FETCH_DATA}, {16'd0, NOP});

    // INIT: 32 edges; fetch during INIT and at the entering edge both return NOP, invalid
    RST_N = 1'b1;
    dones = 0;
    for (int c = 1; c <= 31; c++) begin
      if (c == 10) fetch(3, 1'b0, NOP);
      else tick();
      if (LD_DONE) dones++;
    end
    chk("init_not_ready_31", {31'd0, PROG_READY}, 32'd0);
    fetch(7, 1'b0, NOP);
    chk("init_ready_32", {31'd0, PROG_READY}, 32'd1);
    chk("init_no_done", dones + LD_DONE, 32'd0);
    fetch(7, 1'b1, NOP);

    // Short program with LD_LAST -> padding
    ld_words[0] = 16'h002A; ld_words[1] = 16'h0015; ld_words[2] = 16'h003F;
    run_load(3, 1'b1, 1'b0, 1'b0);
    for (int a = 0; a < 5; a++) fetch(a, 1'b1, mdl[a]);

    // Backpressure gaps, word held in the start cycle, fetch held during LOAD
    for (int i = 0; i < 7; i++) ld_words[i] = 16'h1230 + 16'(i * 7);
    run_load(7, 1'b1, 1'b1, 1'b1);
    read_all();

    // Full depth without LD_LAST -> overflow
    for (int i = 0; i < 32; i++) ld_words[i] = 16'h0100 + 16'(i);
    run_load(32, 1'b0, 1'b0, 1'b0);
    fetch(31, 1'b1, 16'h011F);
    read_all();

    // Full depth with LD_LAST on the final word -> no overflow; start clears previous OVF
    for (int i = 0; i < 32; i++) ld_words[i] = 16'h5000 ^ 16'(i * 129);
    run_load(32, 1'b1, 1'b0, 1'b0);
    read_all();

    // Reset in the middle of a load
    LD_START = 1'b1;
    tick();
    LD_START = 1'b0;
    LD_VALID = 1'b1;
    LD_DATA  = 16'h7777;
    tick();
    LD_DATA  = 16'h8888;
    tick();
    LD_VALID = 1'b0;
    RST_N    = 1'b0;
    tick();
    RST_N = 1'b1;
    chk("abort_ld_ready", {31'd0, LD_READY}, 32'd0);
    chk("abort_prog_ready", {31'd0, PROG_READY}, 32'd0);
    dones = 0;
    for (int c = 1; c <= 32; c++) begin
      if (LD_DONE) dones++;
      tick();
      if (c == 31) chk("reinit_not_ready_31", {31'd0, PROG_READY}, 32'd0);
    end
    chk("reinit_ready_32", {31'd0, PROG_READY}, 32'd1);
    chk("reinit_no_done", dones + LD_DONE, 32'd0);
    for (int i = 0; i < 32; i++) mdl[i] = NOP;
    read_all();
    chk("fetch_queue_drained", fq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
